// File: rtl/fpu_coprocessor_pipe.sv
// Pipelined COP1 unit: instruction decoder, combinational FPU core and a LAT-stage
// execute pipeline with per-register and per-flag scoreboards guarding issue.

package fpu_coprocessor_pipe_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MOV, OP_NEG, OP_ABS, OP_CEQ, OP_CLT, OP_CLE
  } fpu_op_e;
endpackage

// Maps the fop/fn fields to an instruction class, source usage and FPU operation.
module fpu_inst_decoder
  import fpu_coprocessor_pipe_pkg::*;
(
  input  logic [4:0] fop,
  input  logic [5:0] fn,
  output logic       write_en,
  output logic       flag_en,
  output logic       from_cpu,
  output logic       use_fs,
  output logic       use_ft,
  output fpu_op_e    op_code
);
  localparam logic [4:0] FOP_MT = 5'h04;
  localparam logic [4:0] FOP_S  = 5'h10;

  always_comb begin
    write_en = 1'b0;
    flag_en  = 1'b0;
    from_cpu = 1'b0;
    use_fs   = 1'b1;
    use_ft   = 1'b0;
    op_code  = OP_ADD;
    case (fop)
      FOP_MT: begin
        write_en = 1'b1;
        from_cpu = 1'b1;
        use_fs   = 1'b0;
      end
      FOP_S: begin
        case (fn)
          6'h00: begin write_en = 1'b1; use_ft = 1'b1; op_code = OP_ADD; end
          6'h01: begin write_en = 1'b1; use_ft = 1'b1; op_code = OP_SUB; end
          6'h05: begin write_en = 1'b1; op_code = OP_ABS; end
          6'h06: begin write_en = 1'b1; op_code = OP_MOV; end
          6'h07: begin write_en = 1'b1; op_code = OP_NEG; end
          6'h32: begin flag_en = 1'b1; use_ft = 1'b1; op_code = OP_CEQ; end
          6'h3C: begin flag_en = 1'b1; use_ft = 1'b1; op_code = OP_CLT; end
          6'h3E: begin flag_en = 1'b1; use_ft = 1'b1; op_code = OP_CLE; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// Single-precision arithmetic and compares; denormals flush to zero, NaNs are not special-cased.
module fpu_core
  import fpu_coprocessor_pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  fpu_op_e     op,
  output logic [31:0] res
);
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    logic [27:0] ma, mb, mask, sum;
    logic [24:0] mant;
    logic [7:0]  d;
    logic        sticky, rnd;
    int          e;
    p = (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
    q = (y[30:23] == 8'd0) ? {y[31], 31'd0} : y;
    if (p[30:0] < q[30:0]) begin t = p; p = q; q = t; end
    if (p[30:23] == 8'hFF) return p;
    if (q[30:23] == 8'd0) return (p[30:0] == 31'd0) ? {p[31] & q[31], 31'd0} : p;
    ma = {2'b01, p[22:0], 3'b000};
    mb = {2'b01, q[22:0], 3'b000};
    d  = p[30:23] - q[30:23];
    sticky = 1'b0;
    // Shift the smaller operand right, folding lost bits into the sticky position
    if (d > 8'd26) begin
      mb = 28'd1;
    end else begin
      mask   = (28'd1 << d) - 28'd1;
      sticky = |(mb & mask);
      mb     = (mb >> d) | {27'd0, sticky};
    end
    sum = (p[31] == q[31]) ? ma + mb : ma - mb;
    e   = int'(p[30:23]);
    if (sum == 28'd0) return 32'd0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:1]} | {27'd0, sum[0]};
      e   = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26]) begin
        sum = sum << 1;
        e   = e - 1;
      end
    end
    rnd  = sum[2] & (sum[3] | sum[1] | sum[0]);
    mant = {1'b0, sum[26:3]} + {24'd0, rnd};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {p[31], 8'hFF, 23'd0};
    if (e <= 0) return {p[31], 31'd0};
    return {p[31], 8'(e), mant[22:0]};
  endfunction

  function automatic logic feq(input logic [31:0] x, input logic [31:0] y);
    return ((x[30:23] == 8'd0) && (y[30:23] == 8'd0)) || (x == y);
  endfunction

  function automatic logic flt(input logic [31:0] x, input logic [31:0] y);
    logic xz, yz;
    xz = (x[30:23] == 8'd0);
    yz = (y[30:23] == 8'd0);
    if (xz && yz) return 1'b0;
    if (xz) return !y[31];
    if (yz) return x[31];
    if (x[31] != y[31]) return x[31];
    if (x[31]) return x[30:0] > y[30:0];
    return x[30:0] < y[30:0];
  endfunction

  always_comb begin
    res = 32'd0;
    case (op)
      OP_ADD: res = fadd(a, b);
      OP_SUB: res = fadd(a, {~b[31], b[30:0]});
      OP_MOV: res = a;
      OP_NEG: res = {~a[31], a[30:0]};
      OP_ABS: res = {1'b0, a[30:0]};
      OP_CEQ: res = {31'd0, feq(a, b)};
      OP_CLT: res = {31'd0, flt(a, b)};
      OP_CLE: res = {31'd0, flt(a, b) | feq(a, b)};
      default: res = 32'd0;
    endcase
  end
endmodule

module fpu_coprocessor_pipe
  import fpu_coprocessor_pipe_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned NFLAGS = 8,
  parameter int unsigned LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [NFLAGS-1:0] flags,
  output logic [NFLAGS-1:0] flag_pend,
  output logic              busy
);
  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned FW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
  localparam logic [5:0]  OPC_COP1 = 6'h11;

  logic          write_en, flag_en, from_cpu, use_fs, use_ft;
  fpu_op_e       dec_op;
  logic          cop1, is_read, stall_c, accept, issue;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx;
  logic [FW-1:0] cond_idx;

  logic [LAT:1]  vld_q, vld_d, flg_q, flg_d;
  logic [4:0]    dst_q [1:LAT];
  logic [4:0]    dst_d [1:LAT];
  logic [31:0]   res_q [1:LAT];
  logic [31:0]   res_d [1:LAT];
  logic [31:0]   a_q, a_d, b_q, b_d;
  fpu_op_e       op_q, op_d;
  logic          cpu_q, cpu_d;

  logic [NREG-1:0]   pend_q, pend_d;
  logic [NFLAGS-1:0] fpend_q, fpend_d, flags_q, flags_d;
  logic [31:0]       rf_q [NREG];
  logic [31:0]       rf_d [NREG];
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;

  logic [31:0] core_res, s1_res, wb_res;
  logic        wb_vld, wb_flag;
  logic [4:0]  wb_dst;

  fpu_inst_decoder u_dec (
    .fop      (inst[25:21]),
    .fn       (inst[5:0]),
    .write_en (write_en),
    .flag_en  (flag_en),
    .from_cpu (from_cpu),
    .use_fs   (use_fs),
    .use_ft   (use_ft),
    .op_code  (dec_op)
  );

  fpu_core u_core (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (core_res)
  );

  assign cop1     = (inst[31:26] == OPC_COP1);
  assign is_read  = cop1 & ~write_en & ~flag_en;
  assign rt_idx   = inst[16 +: RW];
  assign rs_idx   = inst[11 +: RW];
  assign rd_idx   = inst[6 +: RW];
  assign cond_idx = inst[8 +: FW];

  // RAW on sources, WAW on destination, and in-flight flag writes hold issue
  assign stall_c = cop1 & ((use_fs & pend_q[rs_idx]) | (use_ft & pend_q[rt_idx]) |
                           (write_en & pend_q[rd_idx]) | (flag_en & fpend_q[cond_idx]));
  assign inst_ready = rst_n & ~stall_c;
  assign accept     = inst_valid & inst_ready;
  assign issue      = accept & cop1 & (write_en | flag_en);

  assign s1_res  = cpu_q ? res_q[1] : core_res;
  assign wb_vld  = vld_q[LAT];
  assign wb_flag = flg_q[LAT];
  assign wb_dst  = dst_q[LAT];
  assign wb_res  = (LAT == 1) ? s1_res : res_q[LAT];

  always_comb begin
    vld_d       = vld_q;
    flg_d       = flg_q;
    dst_d       = dst_q;
    res_d       = res_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cpu_d       = cpu_q;
    pend_d      = pend_q;
    fpend_d     = fpend_q;
    rf_d        = rf_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    for (int k = 2; k <= int'(LAT); k++) begin
      vld_d[k] = vld_q[k-1];
      flg_d[k] = flg_q[k-1];
      dst_d[k] = dst_q[k-1];
      res_d[k] = (k == 2) ? s1_res : res_q[k-1];
    end

    vld_d[1] = issue;
    if (issue) begin
      flg_d[1] = flag_en;
      dst_d[1] = flag_en ? 5'(cond_idx) : 5'(rd_idx);
      res_d[1] = in_data;
      a_d      = rf_q[rs_idx];
      b_d      = rf_q[rt_idx];
      op_d     = dec_op;
      cpu_d    = from_cpu;
    end

    // Clear before set: WAW stalls guarantee set and clear never share an index
    if (wb_vld && !wb_flag) begin
      rf_d[wb_dst[RW-1:0]]   = wb_res;
      pend_d[wb_dst[RW-1:0]] = 1'b0;
    end
    if (wb_vld && wb_flag) begin
      flags_d[wb_dst[FW-1:0]] = wb_res[0];
      fpend_d[wb_dst[FW-1:0]] = 1'b0;
    end
    if (issue && write_en) pend_d[rd_idx] = 1'b1;
    if (issue && flag_en)  fpend_d[cond_idx] = 1'b1;

    if (accept && is_read) begin
      out_valid_d = 1'b1;
      out_data_d  = rf_q[rs_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      flg_q <= '0;
      for (int k = 1; k <= int'(LAT); k++) begin
        dst_q[k] <= '0;
        res_q[k] <= '0;
      end
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      cpu_q       <= 1'b0;
      pend_q      <= '0;
      fpend_q     <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      flg_q       <= flg_d;
      dst_q       <= dst_d;
      res_q       <= res_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cpu_q       <= cpu_d;
      pend_q      <= pend_d;
      fpend_q     <= fpend_d;
      rf_q        <= rf_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flags     = flags_q;
  assign flag_pend = fpend_q;
  assign busy      = |vld_q;
endmodule

// File: tb/tb_fpu_coprocessor_pipe.sv
// Bench for fpu_coprocessor_pipe: vector table with expected stall counts, read scoreboard,
// and hand sequences for flag hazards and mid-flight reset.
module tb_fpu_coprocessor_pipe;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, inst_valid, inst_ready, out_valid, busy;
  logic [31:0] inst, in_data, out_data;
  logic [7:0]  flags, flag_pend;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] data;
    logic        rd;
    logic [31:0] expv;
    int          stalls;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fpu_coprocessor_pipe #(.NREG(32), .NFLAGS(8), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .flags(flags), .flag_pend(flag_pend), .busy(busy)
  );

  function automatic logic [31:0] mtc1(input logic [4:0] fd);
    return {6'h11, 5'h04, 5'd0, 5'd0, fd, 6'd0};
  endfunction
  function automatic logic [31:0] mfc1(input logic [4:0] fs);
    return {6'h11, 5'h00, 5'd0, fs, 5'd0, 6'd0};
  endfunction
  function automatic logic [31:0] fops(input logic [5:0] fn, input logic [4:0] fd,
                                       input logic [4:0] fs, input logic [4:0] ft);
    return {6'h11, 5'h10, ft, fs, fd, fn};
  endfunction
  function automatic logic [31:0] fcmp(input logic [5:0] fn, input logic [2:0] cond,
                                       input logic [4:0] fs, input logic [4:0] ft);
    return fops(fn, {cond, 2'b00}, fs, ft);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding read
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: out_data=%h with no read outstanding", out_data);
      end else begin
        check32("read_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input string name, input logic [31:0] i, input logic [31:0] d,
                      input logic rd, input logic [31:0] expv, input int exp_stalls);
    int stalls;
    stalls = 0;
    inst = i;
    in_data = d;
    inst_valid = 1'b1;
    #1;
    while (inst_ready !== 1'b1 && stalls < 50) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (inst_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: inst=%h never accepted", name, i);
    end else begin
      if (rd) exp_q.push_back(expv);
      checks++;
      if (stalls != exp_stalls) begin
        errors++;
        $display("FAIL %s_stalls: got %0d expected %0d", name, stalls, exp_stalls);
      end
    end
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rows: inst, in_data, is_read, expected read data, expected stall cycles
    vecs.push_back('{mfc1(5'd2), 32'h0, 1'b1, 32'h0, 0});
    vecs.push_back('{mtc1(5'd2), 32'h3F800000, 1'b0, 32'h0, 0});
    vecs.push_back('{mfc1(5'd2), 32'h0, 1'b1, 32'h3F800000, 3});
    vecs.push_back('{mtc1(5'd1), 32'h3F800000, 1'b0, 32'h0, 0});
    vecs.push_back('{mtc1(5'd3), 32'h40000000, 1'b0, 32'h0, 0});
    vecs.push_back('{fops(6'h00, 5'd4, 5'd1, 5'd3), 32'h0, 1'b0, 32'h0, 3});
    vecs.push_back('{fops(6'h00, 5'd5, 5'd1, 5'd1), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{fops(6'h00, 5'd6, 5'd3, 5'd3), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{mfc1(5'd4), 32'h0, 1'b1, 32'h40400000, 1});
    vecs.push_back('{mfc1(5'd5), 32'h0, 1'b1, 32'h40000000, 0});
    vecs.push_back('{mfc1(5'd6), 32'h0, 1'b1, 32'h40800000, 0});
    vecs.push_back('{{6'h12, 5'h00, 5'd0, 5'd2, 5'd0, 6'd0}, 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{fops(6'h01, 5'd7, 5'd3, 5'd1), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{fops(6'h07, 5'd8, 5'd3, 5'd0), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{mfc1(5'd7), 32'h0, 1'b1, 32'h3F800000, 2});
    vecs.push_back('{mfc1(5'd8), 32'h0, 1'b1, 32'hC0000000, 0});
    vecs.push_back('{fops(6'h05, 5'd9, 5'd8, 5'd0), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{mfc1(5'd9), 32'h0, 1'b1, 32'h40000000, 3});
    vecs.push_back('{fops(6'h00, 5'd4, 5'd1, 5'd3), 32'h0, 1'b0, 32'h0, 0});
    vecs.push_back('{mtc1(5'd4), 32'h12345678, 1'b0, 32'h0, 3});
    vecs.push_back('{mfc1(5'd4), 32'h0, 1'b1, 32'h12345678, 3});
    vecs.push_back('{mtc1(5'd0), 32'h7F7FFFFF, 1'b0, 32'h0, 0});
    vecs.push_back('{fops(6'h00, 5'd13, 5'd0, 5'd0), 32'h0, 1'b0, 32'h0, 3});
    vecs.push_back('{mfc1(5'd13), 32'h0, 1'b1, 32'h7F800000, 3});

    // Reset held with a valid mtc1 presented: it must not be accepted
    rst_n = 1'b0;
    inst_valid = 1'b1;
    inst = mtc1(5'd2);
    in_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check32("reset_ready", 32'(inst_ready), 32'd1);
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_flags", 32'(flags), 32'd0);
    check32("reset_flag_pend", 32'(flag_pend), 32'd0);
    check32("reset_out_valid", 32'(out_valid), 32'd0);
    check32("reset_out_data", out_data, 32'd0);

    foreach (vecs[n])
      send($sformatf("vec%0d", n), vecs[n].inst, vecs[n].data, vecs[n].rd, vecs[n].expv,
           vecs[n].stalls);
    cycles(LAT + 2);
    check32("drain_busy", 32'(busy), 32'd0);
    check32("drain_reads", 32'(exp_q.size()), 32'd0);

    // c.lt.s cond 2 with f1(1.0) < f3(2.0): pending for LAT cycles, then committed
    send("clt2", fcmp(6'h3C, 3'd2, 5'd1, 5'd3), 32'h0, 1'b0, 32'h0, 0);
    for (int k = 0; k < LAT; k++) begin
      check32($sformatf("clt2_pend%0d", k), 32'(flag_pend), 32'h04);
      check32($sformatf("clt2_flags%0d", k), 32'(flags), 32'h00);
      @(posedge clk);
      #1;
    end
    check32("clt2_pend_done", 32'(flag_pend), 32'h00);
    check32("clt2_flags_done", 32'(flags), 32'h04);

    // Same-flag hazard stalls; an independent flag issues freely
    send("clt2_false", fcmp(6'h3C, 3'd2, 5'd3, 5'd1), 32'h0, 1'b0, 32'h0, 0);
    send("clt5", fcmp(6'h3C, 3'd5, 5'd1, 5'd3), 32'h0, 1'b0, 32'h0, 0);
    send("ceq2", fcmp(6'h32, 3'd2, 5'd1, 5'd1), 32'h0, 1'b0, 32'h0, 2);
    check32("ceq2_flags_mid", 32'(flags), 32'h20);
    check32("ceq2_pend_mid", 32'(flag_pend), 32'h04);
    cycles(LAT);
    check32("ceq2_flags_done", 32'(flags), 32'h24);
    check32("ceq2_pend_done", 32'(flag_pend), 32'h00);

    // Reset with the pipeline full: nothing in flight may write back
    send("rst_w10", mtc1(5'd10), 32'hAAAA5555, 1'b0, 32'h0, 0);
    send("rst_w11", mtc1(5'd11), 32'h5555AAAA, 1'b0, 32'h0, 0);
    send("rst_clt3", fcmp(6'h3C, 3'd3, 5'd1, 5'd3), 32'h0, 1'b0, 32'h0, 0);
    check32("full_busy", 32'(busy), 32'd1);
    check32("full_flag_pend", 32'(flag_pend), 32'h08);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check32("midrst_busy", 32'(busy), 32'd0);
    check32("midrst_flag_pend", 32'(flag_pend), 32'h00);
    check32("midrst_flags", 32'(flags), 32'h00);
    cycles(LAT + 1);
    check32("midrst_flags_later", 32'(flags), 32'h00);
    check32("midrst_busy_later", 32'(busy), 32'd0);
    send("rd_f10", mfc1(5'd10), 32'h0, 1'b1, 32'h0, 0);
    send("rd_f11", mfc1(5'd11), 32'h0, 1'b1, 32'h0, 0);
    send("rd_f2", mfc1(5'd2), 32'h0, 1'b1, 32'h0, 0);
    send("rd_f4", mfc1(5'd4), 32'h0, 1'b1, 32'h0, 0);
    cycles(2);
    check32("final_reads", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
